// File: rtl/uart_pkg.sv
// uart_pkg: shared UART clocking constants, preset oversample divisors and the rounded-divisor helper
package uart_pkg;
  localparam int CLK_HZ_DEFAULT = 50_000_000;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + baud * os / 2) / (baud * os);
  endfunction
  localparam int DIV_9600 = calc_div(CLK_HZ_DEFAULT, 9600, 16);
  localparam int DIV_19200 = calc_div(CLK_HZ_DEFAULT, 19200, 16);
  localparam int DIV_57600 = calc_div(CLK_HZ_DEFAULT, 57600, 16);
  localparam int DIV_115200 = calc_div(CLK_HZ_DEFAULT, 115200, 16);
endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control in (en, div_load, div_value, sync) and timing out (tick_os, tick_mid, tick_bit, baud_clk, div_cur)
interface baud_tick_gen_if #(
  parameter int DIV_W = 16
);
  logic en;
  logic div_load;
  logic [DIV_W-1:0] div_value;
  logic sync;
  logic tick_os;
  logic tick_mid;
  logic tick_bit;
  logic baud_clk;
  logic [DIV_W-1:0] div_cur;
  modport master(
    output en, div_load, div_value, sync,
    input tick_os, tick_mid, tick_bit, baud_clk, div_cur
  );
  modport slave(
    input en, div_load, div_value, sync,
    output tick_os, tick_mid, tick_bit, baud_clk, div_cur
  );
endinterface

// File: rtl/baud_prescaler.sv
// baud_prescaler: divisor register with clamp, oversample counter; wrap (comb, restart-suppressed) and registered tick_os, div_cur out
module baud_prescaler #(
  parameter int DIV_W = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 27
) (
  input  logic             fin,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             clr,
  output logic             wrap,
  output logic             tick_os,
  output logic [DIV_W-1:0] div_cur
);
  logic [DIV_W-1:0] div_q, div_d, os_cnt_q, os_cnt_d;
  logic tick_os_q, tick_os_d;
  always_comb begin
    wrap = en && !div_load && !clr && os_cnt_q == div_q - DIV_W'(1);
    div_d = !div_load ? div_q : div_value < DIV_W'(2) ? DIV_W'(2) : div_value;
    os_cnt_d = (div_load || clr || wrap) ? '0 : en ? os_cnt_q + DIV_W'(1) : os_cnt_q;
    tick_os_d = wrap;
  end
  always_ff @(posedge fin) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      os_cnt_q <= '0;
      tick_os_q <= 1'b0;
    end else begin
      div_q <= div_d;
      os_cnt_q <= os_cnt_d;
      tick_os_q <= tick_os_d;
    end
  end
  assign tick_os = tick_os_q;
  assign div_cur = div_q;
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud timing; fin clock, rst sync reset, bus slave carries en/div_load/div_value/sync in and tick_os/tick_mid/tick_bit/baud_clk/div_cur out
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BAUD = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input logic fin,
  input logic rst,
  baud_tick_gen_if.slave bus
);
  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] MID = BW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] HALF = BW'(OVERSAMPLE / 2);
  logic wrap;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic tick_mid_q, tick_mid_d, tick_bit_q, tick_bit_d, baud_clk_q, baud_clk_d;
  baud_prescaler #(
    .DIV_W(DIV_W),
    .DEFAULT_DIV(DIV_W'(DEFAULT_DIV))
  ) u_pre (
    .fin(fin),
    .rst(rst),
    .en(bus.en),
    .div_load(bus.div_load),
    .div_value(bus.div_value),
    .clr(bus.sync),
    .wrap(wrap),
    .tick_os(bus.tick_os),
    .div_cur(bus.div_cur)
  );
  always_comb begin
    bit_cnt_d = (bus.div_load || bus.sync) ? '0 : !wrap ? bit_cnt_q : bit_cnt_q == LAST ? '0 : bit_cnt_q + BW'(1);
    tick_mid_d = wrap && bit_cnt_q == MID;
    tick_bit_d = wrap && bit_cnt_q == LAST;
    baud_clk_d = bit_cnt_d >= HALF;
  end
  always_ff @(posedge fin) begin
    if (rst) begin
      bit_cnt_q <= '0;
      tick_mid_q <= 1'b0;
      tick_bit_q <= 1'b0;
      baud_clk_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      tick_mid_q <= tick_mid_d;
      tick_bit_q <= tick_bit_d;
      baud_clk_q <= baud_clk_d;
    end
  end
  assign bus.tick_mid = tick_mid_q;
  assign bus.tick_bit = tick_bit_q;
  assign bus.baud_clk = baud_clk_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: randomized and directed checks of baud_tick_gen against a phase-count reference model
module tb_baud_tick_gen;
  import uart_pkg::*;
  logic fin = 1'b0;
  logic rst = 1'b1;
  baud_tick_gen_if #(.DIV_W(16)) bus();
  baud_tick_gen dut (
    .fin(fin),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 fin = ~fin;
  int total = 0;
  int bad = 0;
  int p = 0;
  int d = 27;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic e, input logic ld, input int v, input logic s);
    rst = r;
    bus.en = e;
    bus.div_load = ld;
    bus.div_value = 16'(v);
    bus.sync = s;
  endtask
  task automatic step();
    bit restart, e_os, e_mid, e_bit, e_bc;
    int per, ph;
    @(posedge fin);
    restart = rst || bus.div_load || bus.sync;
    if (rst) begin
      d = 27;
      p = 0;
    end else if (restart) begin
      if (bus.div_load) d = (bus.div_value < 2) ? 2 : int'(bus.div_value);
      p = 0;
    end else if (bus.en) p++;
    per = d * 16;
    ph = p % per;
    e_os = !restart && bus.en && (p % d == 0);
    e_mid = !restart && bus.en && ph == d * 8;
    e_bit = !restart && bus.en && ph == 0;
    e_bc = ph >= d * 8;
    #1;
    chk("tick_os", int'(bus.tick_os), int'(e_os));
    chk("tick_mid", int'(bus.tick_mid), int'(e_mid));
    chk("tick_bit", int'(bus.tick_bit), int'(e_bit));
    chk("baud_clk", int'(bus.baud_clk), int'(e_bc));
    chk("div_cur", int'(bus.div_cur), d);
  endtask
  task automatic wait_for(input int sel, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if ((sel == 0 && bus.tick_os) || (sel == 1 && bus.tick_mid) || (sel == 2 && bus.tick_bit)) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int n, n2, n3;
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) step();
    chk("rst_div_cur", int'(bus.div_cur), 27);
    chk("rst_baud_clk", int'(bus.baud_clk), 0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_for(0, 100, n);
    chk("first_os", n, 27);
    wait_for(1, 400, n2);
    chk("first_mid", n + n2, 216);
    wait_for(2, 400, n3);
    chk("first_bit", n + n2 + n3, 432);
    repeat (1000 - (n + n2 + n3)) step();
    drive(1'b0, 1'b1, 1'b1, 4, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("load4_div_cur", int'(bus.div_cur), 4);
    wait_for(1, 100, n);
    chk("load4_mid", n, 32);
    wait_for(2, 100, n2);
    chk("load4_bit", n + n2, 64);
    wait_for(2, 100, n);
    chk("load4_bit_period", n, 64);
    for (int v = 0; v < 2; v++) begin
      drive(1'b0, 1'b1, 1'b1, v, 1'b0);
      step();
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
      chk("clamp_div_cur", int'(bus.div_cur), 2);
      wait_for(0, 10, n);
      chk("clamp_os", n, 2);
      wait_for(2, 100, n2);
      chk("clamp_bit", n + n2, 32);
    end
    drive(1'b0, 1'b1, 1'b1, 4, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("sync_no_os", int'(bus.tick_os), 0);
    chk("sync_bc", int'(bus.baud_clk), 0);
    wait_for(1, 100, n);
    chk("sync_mid", n, 32);
    drive(1'b0, 1'b1, 1'b1, 4, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (20) step();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (10) step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_for(2, 200, n);
    chk("pause_bit", 30 + n, 74);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 99) == 0, int'($urandom_range(0, 8)),
            $urandom_range(0, 99) == 0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 4, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (40) step();
    drive(1'b1, 1'b1, 1'b1, 9, 1'b1);
    step();
    chk("rst_mix_div_cur", int'(bus.div_cur), 27);
    chk("rst_mix_bc", int'(bus.baud_clk), 0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_for(0, 100, n);
    chk("rst_mix_os", n, 27);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
